// File: rtl/fas_freq_analysis.sv
// Finds the dominant bin of each 16-point FFT frame from squared magnitudes, evaluating one bin per cycle.
// Latency: fft_valid at edge T -> done high after edge T+17; accepts a new frame every 16 cycles with no bubble.
// No backpressure: a frame arriving mid-analysis is dropped and flagged on the sticky overrun output.
module fas_freq_analysis #(
    parameter int DW  = 16,
    parameter int NPT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fft_valid,
    input  logic [2*DW-1:0] fft_d0,
    input  logic [2*DW-1:0] fft_d1,
    input  logic [2*DW-1:0] fft_d2,
    input  logic [2*DW-1:0] fft_d3,
    input  logic [2*DW-1:0] fft_d4,
    input  logic [2*DW-1:0] fft_d5,
    input  logic [2*DW-1:0] fft_d6,
    input  logic [2*DW-1:0] fft_d7,
    input  logic [2*DW-1:0] fft_d8,
    input  logic [2*DW-1:0] fft_d9,
    input  logic [2*DW-1:0] fft_d10,
    input  logic [2*DW-1:0] fft_d11,
    input  logic [2*DW-1:0] fft_d12,
    input  logic [2*DW-1:0] fft_d13,
    input  logic [2*DW-1:0] fft_d14,
    input  logic [2*DW-1:0] fft_d15,
    output logic            done,
    output logic [3:0]      freq,
    output logic [2*DW-1:0] mag_max,
    output logic            overrun
);

    localparam logic [3:0] LAST_IDX = 4'(NPT - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             idx_q;
    logic signed [DW-1:0]   re_q [NPT];
    logic signed [DW-1:0]   im_q [NPT];
    logic [2*DW-1:0]        d_in [NPT];
    logic [2*DW-1:0]        run_max_q;
    logic [3:0]             run_idx_q;
    logic                   fin_q;
    logic                   load, last, ovr_set;

    assign d_in[0]  = fft_d0;
    assign d_in[1]  = fft_d1;
    assign d_in[2]  = fft_d2;
    assign d_in[3]  = fft_d3;
    assign d_in[4]  = fft_d4;
    assign d_in[5]  = fft_d5;
    assign d_in[6]  = fft_d6;
    assign d_in[7]  = fft_d7;
    assign d_in[8]  = fft_d8;
    assign d_in[9]  = fft_d9;
    assign d_in[10] = fft_d10;
    assign d_in[11] = fft_d11;
    assign d_in[12] = fft_d12;
    assign d_in[13] = fft_d13;
    assign d_in[14] = fft_d14;
    assign d_in[15] = fft_d15;

    // Magnitude path: sign-extend, square in 2*DW bits; the unsigned sum peaks at 2^31 and cannot wrap.
    logic signed [DW-1:0]   cur_re, cur_im;
    logic signed [2*DW-1:0] re_x, im_x, re_sq, im_sq;
    logic [2*DW-1:0]        mag;

    assign cur_re = re_q[idx_q];
    assign cur_im = im_q[idx_q];
    assign re_x   = {{DW{cur_re[DW-1]}}, cur_re};
    assign im_x   = {{DW{cur_im[DW-1]}}, cur_im};
    assign re_sq  = re_x * re_x;
    assign im_sq  = im_x * im_x;
    assign mag    = $unsigned(re_sq) + $unsigned(im_sq);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        last    = 1'b0;
        ovr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (fft_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx_q == LAST_IDX) begin
                    last = 1'b1;
                    if (fft_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (fft_valid) begin
                    ovr_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            run_max_q <= '0;
            run_idx_q <= '0;
            fin_q     <= 1'b0;
            done      <= 1'b0;
            freq      <= '0;
            mag_max   <= '0;
            overrun   <= 1'b0;
            for (int k = 0; k < NPT; k++) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;

            if (load) begin
                idx_q <= '0;
                for (int k = 0; k < NPT; k++) begin
                    re_q[k] <= d_in[k][2*DW-1:DW];
                    im_q[k] <= d_in[k][DW-1:0];
                end
            end else if (last) begin
                idx_q <= '0;
            end else if (state_q == RUN) begin
                idx_q <= idx_q + 4'd1;
            end

            // Bin 0 seeds the running max; later bins win only when strictly larger, so ties keep the lower index.
            if (state_q == RUN && (idx_q == 4'd0 || mag > run_max_q)) begin
                run_max_q <= mag;
                run_idx_q <= idx_q;
            end

            fin_q <= last;
            done  <= fin_q;
            if (fin_q) begin
                freq    <= run_idx_q;
                mag_max <= run_max_q;
            end

            if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fas_freq_analysis.sv
// Randomized and directed stimulus for fas_freq_analysis, scored against a frame-level reference model.
module tb_fas_freq_analysis;

    logic        clk = 1'b0;
    logic        rst;
    logic        fft_valid;
    logic [31:0] d [16];
    logic        done;
    logic [3:0]  freq;
    logic [31:0] mag_max;
    logic        overrun;

    always #5 clk = ~clk;

    fas_freq_analysis #(.DW(16), .NPT(16)) dut (
        .clk(clk), .rst(rst), .fft_valid(fft_valid),
        .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
        .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
        .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
        .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
        .done(done), .freq(freq), .mag_max(mag_max), .overrun(overrun)
    );

    typedef struct {
        int          t;
        logic [3:0]  f;
        logic [31:0] m;
    } exp_t;

    exp_t        pend [$];
    int          edge_n   = 0;
    int          last_acc = -100;
    int          n_tests  = 0;
    int          n_fail   = 0;
    logic        exp_done;
    logic [3:0]  exp_freq = '0;
    logic [31:0] exp_mag  = '0;
    logic        exp_ovr  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h, want %h", tag, edge_n, got, want);
        end
    endtask

    // Reference: plain integer power per bin, first strict maximum wins.
    task automatic ref_frame(output logic [3:0] f, output logic [31:0] m);
        longint best;
        longint p;
        int     re, im;
        best = -1;
        f    = '0;
        for (int k = 0; k < 16; k++) begin
            re = int'($signed(d[k][31:16]));
            im = int'($signed(d[k][15:0]));
            p  = longint'(re) * re + longint'(im) * im;
            if (p > best) begin
                best = p;
                f    = 4'(k);
            end
        end
        m = best[31:0];
    endtask

    task automatic step(input logic v, input logic r);
        exp_t e;
        fft_valid = v;
        rst       = r;
        @(posedge clk);
        edge_n++;
        if (r) begin
            pend.delete();
            last_acc = -100;
            exp_freq = '0;
            exp_mag  = '0;
            exp_ovr  = 1'b0;
        end else if (v) begin
            if (edge_n - last_acc < 16) begin
                exp_ovr = 1'b1;
            end else begin
                e.t = edge_n + 17;
                ref_frame(e.f, e.m);
                pend.push_back(e);
                last_acc = edge_n;
            end
        end
        @(negedge clk);
        exp_done = (pend.size() > 0) && (pend[0].t == edge_n);
        if (exp_done) begin
            exp_freq = pend[0].f;
            exp_mag  = pend[0].m;
            void'(pend.pop_front());
        end
        chk("done", 32'(done), 32'(exp_done));
        chk("freq", 32'(freq), 32'(exp_freq));
        chk("mag_max", mag_max, exp_mag);
        chk("overrun", 32'(overrun), 32'(exp_ovr));
        fft_valid = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic scramble();
        for (int k = 0; k < 16; k++) d[k] = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            scramble();
            step(1'b0, 1'b0);
        end
    endtask

    task automatic clear_frame();
        for (int k = 0; k < 16; k++) d[k] = '0;
    endtask

    initial begin
        fft_valid = 1'b0;
        rst       = 1'b1;
        scramble();

        // Reset and idle
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        idle(20);
        chk("idle_freq", 32'(freq), 32'd0);

        // Single tone
        clear_frame();
        d[1] = 32'h0400_0000;
        step(1'b1, 1'b0);
        idle(20);
        chk("tone_freq", 32'(freq), 32'd1);
        chk("tone_mag", mag_max, 32'h0010_0000);

        // Tie goes to the lower bin, then a larger bin 15 wins
        clear_frame();
        d[1]  = 32'h0300_0400;
        d[15] = 32'h0400_FD00;
        step(1'b1, 1'b0);
        idle(20);
        chk("tie_freq", 32'(freq), 32'd1);
        chk("tie_mag", mag_max, 32'h0019_0000);
        clear_frame();
        d[1]  = 32'h0300_0400;
        d[15] = 32'h0400_FC00;
        step(1'b1, 1'b0);
        idle(20);
        chk("hi15_freq", 32'(freq), 32'd15);
        chk("hi15_mag", mag_max, 32'h0020_0000);

        // Full-scale corner
        for (int k = 0; k < 16; k++) d[k] = 32'h7FFF_0000;
        d[7] = 32'h8000_8000;
        step(1'b1, 1'b0);
        idle(20);
        chk("fs_freq", 32'(freq), 32'd7);
        chk("fs_mag", mag_max, 32'h8000_0000);

        // Back-to-back frames with a rotating peak
        for (int i = 0; i < 8; i++) begin
            clear_frame();
            d[i] = 32'h1000_0100;
            step(1'b1, 1'b0);
            idle(15);
        end
        idle(20);
        chk("b2b_freq", 32'(freq), 32'd7);
        chk("b2b_ovr", 32'(overrun), 32'd0);

        // Overrun: second pulse 5 cycles into a frame
        clear_frame();
        d[9] = 32'h0000_2000;
        step(1'b1, 1'b0);
        idle(4);
        clear_frame();
        d[2] = 32'h7000_7000;
        step(1'b1, 1'b0);
        idle(20);
        chk("ovr_freq", 32'(freq), 32'd9);
        chk("ovr_flag", 32'(overrun), 32'd1);

        // Reset during analysis at idx 8
        clear_frame();
        d[4] = 32'h0100_0100;
        step(1'b1, 1'b0);
        idle(8);
        step(1'b0, 1'b1);
        idle(20);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_mag", mag_max, 32'd0);

        // Frame after reset
        clear_frame();
        d[12] = 32'hFF00_0000;
        step(1'b1, 1'b0);
        idle(20);
        chk("post_freq", 32'(freq), 32'd12);

        // Random traffic: small-valued bins to provoke ties, occasional full-range bins and rare resets
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 16; k++) begin
                if ($urandom_range(0, 3) == 0) d[k] = $urandom;
                else d[k] = {16'($signed(3'($urandom_range(0, 7)))), 16'($signed(3'($urandom_range(0, 7))))};
            end
            if ($urandom_range(0, 299) == 0) step(1'b0, 1'b1);
            else if ($urandom_range(0, 2) == 0) step(1'b0, 1'b0);
            else step(($urandom_range(0, 7) == 0) || (edge_n + 1 - last_acc == 16 && $urandom_range(0, 1) == 0), 1'b0);
        end
        idle(20);
        chk("final_pending", 32'(pend.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fas_freq_analysis.md
Name: fas_freq_analysis

Overview:
- Analysis stage directly downstream of the FAS 16-point FFT.
- Captures each 16-bin FFT frame on fft_valid and computes the squared magnitude of every bin, one bin per cycle.
- Reports the index of the dominant bin on freq, with a one-cycle done pulse.
- Sustains the FFT's fastest frame rate: one frame every 16 cycles.

Parameters:
- DW, 16, width of each real/imag component (signed, 8 integer + 8 fraction).
- NPT, 16, number of FFT bins; fixed at 16, since freq is 4 bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- fft_valid  in  1  one-cycle pulse; fft_d0..fft_d15 hold a complete frame
- fft_d0 .. fft_d15  in  32 each  bin k = {real[31:16], imag[15:0]}, signed two's complement
- done  out  1  one-cycle pulse; freq and mag_max are valid for the frame just analysed
- freq  out  4  index of the maximum-magnitude bin; held until the next done
- mag_max  out  32  unsigned real^2+imag^2 of the winning bin; held with freq
- overrun  out  1  sticky; set when a frame is dropped; cleared only by rst

Behaviour:
- Reset (rst high at a rising edge): state IDLE, idx=0, done=0, freq=0, mag_max=0, overrun=0, frame registers cleared. Reset mid-RUN aborts the frame; no done is produced.
- States: IDLE, RUN.
- IDLE:
  - fft_valid=1 -> latch all 16 inputs into frame registers, idx<=0, go to RUN.
- RUN:
  - Each cycle: mag = re[idx]^2 + im[idx]^2, where re/im are sign-extended and the squares are signed 32-bit. The sum is 32-bit unsigned and cannot overflow: the maximum is 2*(2^15)^2 = 2^31.
  - idx=0: running max <= mag, running index <= 0 (unconditional load).
  - idx>0: update only if mag > running max (strictly greater). Ties therefore go to the lowest index.
  - idx<15: idx<=idx+1.
  - idx=15: the final comparison is made that cycle. Next cycle: done=1, freq/mag_max <= final result.
    - If fft_valid=1 in this cycle: latch the new frame, idx<=0, stay in RUN (back-to-back, no bubble).
    - Otherwise: go to IDLE.
  - fft_valid=1 while idx<15: the frame is ignored, overrun<=1, and the current analysis continues unaffected.
- Latency:
  - fft_valid sampled at edge T.
  - Bins evaluated in cycles T+1 .. T+16.
  - done is high in the cycle following edge T+17.
- done is a registered output: high for exactly one cycle per accepted frame, otherwise 0.
- freq and mag_max change only on the edge that raises done.
- Inputs fft_d* are sampled only on accepted fft_valid edges; their values at all other times are don't-care.
- Only the internal magnitude path is combinational; all outputs are registered.

Test Plan:
1. Reset/idle: hold rst 3 cycles, then idle 20 cycles -> done=0, freq=0, mag_max=0, overrun=0 throughout.
2. Single tone: frame all zero except fft_d1={16'h0400,16'h0000}, one fft_valid pulse at edge T -> done exactly at the cycle after edge T+17, freq=1, mag_max=32'h00100000; done low on the cycle after.
3. Dual tone with tie: fft_d1={16'h0300,16'h0400} and fft_d15={16'h0400,16'hFD00}, both magnitude 0x00190000 -> freq=1 (lowest index wins). Then change d15 imag to 16'hFC00 (magnitude 0x00200000) -> freq=15.
4. Full-scale corner: fft_d7={16'h8000,16'h8000}, all other bins {16'h7FFF,16'h0000} -> freq=7, mag_max=32'h80000000 (no wrap, unsigned compare).
5. Back-to-back frames: pulse fft_valid every 16 cycles for 8 frames, rotating the peak bin 0..7 -> 8 done pulses exactly 16 cycles apart, freq 0,1,...,7 in order, overrun=0.
6. Overrun and mid-run reset:
   - Pulse fft_valid 5 cycles after a frame starts -> first frame still reports correctly, overrun=1 stays high until reset.
   - Assert rst at idx=8 -> no done, all outputs 0.
   - A frame issued after reset is analysed normally.
